// File: rtl/core_sched_pkg.sv
// ============================================================================
// Module  : core_sched_pkg
// Brief   : Shared types, widths and field offsets for the inter-core scheduler.
// Revision: 1.0
// ============================================================================
`default_nettype none

package core_sched_pkg;

    localparam int c_NCORES  = 4;
    localparam int c_PC_W    = 16;
    localparam int c_TGT_W   = 2;
    localparam int c_PR_W    = 4;
    localparam int c_AW_W    = 19;
    localparam int c_PCP_W   = 17;
    localparam int c_STALL_W = 3;

    localparam logic [c_STALL_W-1:0] c_PAUSE_STALL = 3'd6;

    // Field offsets inside one core's request words
    localparam int c_PR_VALID  = 3;
    localparam int c_PR_RESUME = 2;
    localparam int c_AW_VALID  = 18;
    localparam int c_AW_TGT_LO = 16;

    typedef enum logic [1:0] {
        KIND_AWAKEN = 2'd0,
        KIND_PAUSE  = 2'd1,
        KIND_RESUME = 2'd2
    } kind_e;

    typedef enum logic {
        ST_BOOT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    typedef struct packed {
        logic                full;
        kind_e               kind;
        logic [c_TGT_W-1:0]  target;
        logic [c_PC_W-1:0]   pc;
    } slot_t;

    // An awaken request takes priority if a core presents both kinds at once.
    function automatic slot_t decode_req(input logic [c_PR_W-1:0] pr,
                                         input logic [c_AW_W-1:0] aw);
        slot_t s;
        s        = '0;
        s.kind   = KIND_AWAKEN;
        if (aw[c_AW_VALID]) begin
            s.full   = 1'b1;
            s.kind   = KIND_AWAKEN;
            s.target = aw[c_AW_TGT_LO +: c_TGT_W];
            s.pc     = aw[c_PC_W-1:0];
        end else if (pr[c_PR_VALID]) begin
            s.full   = 1'b1;
            s.kind   = pr[c_PR_RESUME] ? KIND_RESUME : KIND_PAUSE;
            s.target = pr[c_TGT_W-1:0];
        end
        return s;
    endfunction

endpackage

`default_nettype wire

// File: rtl/rr_arbiter4.sv
// ============================================================================
// Module  : rr_arbiter4
// Brief   : Combinational 4-way round-robin picker: first request at or after ptr.
// Revision: 1.0
// ============================================================================
`default_nettype none

module rr_arbiter4 (
    input  logic [3:0] i_req,
    input  logic [1:0] i_ptr,
    output logic [3:0] o_grant,
    output logic [1:0] o_idx,
    output logic       o_valid
);

    logic [1:0] w_cand;

    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_valid = 1'b0;
        w_cand  = '0;
        for (int k = 0; k < 4; k++) begin
            w_cand = i_ptr + 2'(k);
            if (!o_valid && i_req[w_cand]) begin
                o_valid = 1'b1;
                o_idx   = w_cand;
            end
        end
        if (o_valid) begin
            o_grant[o_idx] = 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/core_sched.sv
// ============================================================================
// Module  : core_sched
// Brief   : Inter-core scheduler: per-core request slots, round-robin grants,
//           boot of core 0, pause/resume stall control and all-halted flag.
// Revision: 1.0
// ============================================================================
`default_nettype none

module core_sched
    import core_sched_pkg::*;
#(
    parameter int unsigned NCORES      = 4,
    parameter logic [15:0] BOOT_PC     = 16'h0000,
    parameter logic [2:0]  PAUSE_STALL = c_PAUSE_STALL
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*NCORES-1:0]     pr_req,
    input  logic [19*NCORES-1:0]    aw_req,
    input  logic [NCORES-1:0]       core_halt,
    input  logic [NCORES-1:0]       core_awake,
    output logic [17*NCORES-1:0]    pc_passed,
    output logic [3*NCORES-1:0]     stall_num,
    output logic                    all_halted
);

    state_e              r_state;
    state_e              w_state_nxt;
    logic                w_boot_fire;
    logic                w_run;

    slot_t               r_slot [NCORES];
    slot_t               w_req  [NCORES];
    slot_t               w_gslot;

    logic [NCORES-1:0]   w_arb_req;
    logic [NCORES-1:0]   w_gnt;
    logic [1:0]          w_gidx;
    logic                w_gvalid;
    logic [NCORES-1:0]   w_bp;
    logic [NCORES-1:0]   w_load;

    logic [1:0]          r_rr;
    logic [NCORES-1:0]   r_paused;
    logic [c_PCP_W-1:0]  r_pcp [NCORES];
    logic                r_all_halted;

    // ------------------------------------------------------------------
    // Boot FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_BOOT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_boot_fire = 1'b0;
        w_run       = 1'b0;
        case (r_state)
            ST_BOOT: begin
                w_boot_fire = 1'b1;
                w_state_nxt = ST_RUN;
            end
            ST_RUN: begin
                w_run = 1'b1;
            end
            default: begin
                w_state_nxt = ST_BOOT;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Request capture, backpressure and slot storage
    // ------------------------------------------------------------------
    for (genvar i = 0; i < NCORES; i++) begin : g_slot
        assign w_req[i]     = decode_req(pr_req[4*i +: 4], aw_req[19*i +: 19]);
        assign w_arb_req[i] = r_slot[i].full & w_run;
        // A slot accepts a new request when empty or when it drains this cycle.
        assign w_bp[i]      = w_req[i].full & r_slot[i].full & ~w_gnt[i];
        assign w_load[i]    = w_req[i].full & ~w_bp[i];

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_slot[i] <= '0;
            end else if (w_load[i]) begin
                r_slot[i] <= w_req[i];
            end else if (w_gnt[i]) begin
                r_slot[i].full <= 1'b0;
            end
        end
    end

    rr_arbiter4 u_arb (
        .i_req   (w_arb_req),
        .i_ptr   (r_rr),
        .o_grant (w_gnt),
        .o_idx   (w_gidx),
        .o_valid (w_gvalid)
    );

    assign w_gslot = r_slot[w_gidx];

    // ------------------------------------------------------------------
    // Grant effects, registered one cycle after the grant
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rr     <= '0;
            r_paused <= '0;
            r_pcp    <= '{default: '0};
        end else begin
            r_pcp <= '{default: '0};
            if (w_boot_fire) begin
                r_pcp[0] <= {1'b1, BOOT_PC};
            end
            if (w_gvalid) begin
                r_rr <= w_gidx + 2'd1;
                case (w_gslot.kind)
                    KIND_AWAKEN: r_pcp[w_gslot.target]    <= {1'b1, w_gslot.pc};
                    KIND_PAUSE:  r_paused[w_gslot.target] <= 1'b1;
                    KIND_RESUME: r_paused[w_gslot.target] <= 1'b0;
                    default:     ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_all_halted <= 1'b0;
        end else begin
            r_all_halted <= (core_awake != '0) && ((core_awake & ~core_halt) == '0);
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    for (genvar i = 0; i < NCORES; i++) begin : g_out
        assign pc_passed[17*i +: 17] = r_pcp[i];
        assign stall_num[3*i +: 3]   = (r_paused[i] | w_bp[i]) ? PAUSE_STALL : 3'd0;
    end

    assign all_halted = r_all_halted;

endmodule

`default_nettype wire

// File: tb/tb_core_sched.sv
// ============================================================================
// Module  : tb_core_sched
// Brief   : Directed and randomized self-checking bench for core_sched.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_core_sched;

    localparam logic [15:0] BOOT_PC = 16'h0000;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] pr_req;
    logic [75:0] aw_req;
    logic [3:0]  core_halt;
    logic [3:0]  core_awake;
    logic [67:0] pc_passed;
    logic [11:0] stall_num;
    logic        all_halted;

    core_sched dut (
        .clk        (clk),
        .rst        (rst),
        .pr_req     (pr_req),
        .aw_req     (aw_req),
        .core_halt  (core_halt),
        .core_awake (core_awake),
        .pc_passed  (pc_passed),
        .stall_num  (stall_num),
        .all_halted (all_halted)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Requests each core is presenting (kind 0=awaken, 1=pause, 2=resume)
    bit       rq_v    [4];
    int       rq_kind [4];
    int       rq_tgt  [4];
    int       rq_pc   [4];
    bit       rq_both [4];
    bit [2:0] rq_junk [4];

    // Reference model: pending work per core, fairness pointer, pause bits
    typedef struct {
        bit full;
        int kind;
        int tgt;
        int pc;
    } mslot_t;

    mslot_t    m_slot [4];
    int        m_rr;
    bit        m_boot;
    bit [3:0]  m_paused;
    bit [16:0] m_pcp [4];
    bit        m_allh;
    bit        m_last_bp [4];

    task automatic chk(string tag, logic [67:0] got, logic [67:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic expect_pcp(int c, logic [16:0] v, string tag);
        chk(tag, 68'(pc_passed[17*c +: 17]), 68'(v));
    endtask

    task automatic expect_stall(int c, logic [2:0] v, string tag);
        chk(tag, 68'(stall_num[3*c +: 3]), 68'(v));
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_slot[i].full = 1'b0;
            m_slot[i].kind = 0;
            m_slot[i].tgt  = 0;
            m_slot[i].pc   = 0;
            m_pcp[i]       = '0;
            m_last_bp[i]   = 1'b0;
        end
        m_rr     = 0;
        m_boot   = 1'b1;
        m_paused = '0;
        m_allh   = 1'b0;
    endtask

    function automatic int m_grant();
        if (m_boot) return -1;
        for (int k = 0; k < 4; k++) begin
            if (m_slot[(m_rr + k) % 4].full) return (m_rr + k) % 4;
        end
        return -1;
    endfunction

    function automatic bit m_bp(int i, int g);
        return rq_v[i] && m_slot[i].full && (g != i);
    endfunction

    task automatic set_req(int c, int kind, int tgt, int pc);
        rq_v[c]    = 1'b1;
        rq_kind[c] = kind;
        rq_tgt[c]  = tgt;
        rq_pc[c]   = pc;
        rq_both[c] = 1'b0;
    endtask

    task automatic clr_req(int c);
        rq_v[c]    = 1'b0;
        rq_both[c] = 1'b0;
    endtask

    task automatic drive_inputs();
        logic [15:0] pr;
        logic [75:0] aw;
        pr = '0;
        aw = '0;
        for (int i = 0; i < 4; i++) begin
            if (rq_v[i]) begin
                if (rq_kind[i] == 0) begin
                    aw[19*i +: 19] = {1'b1, 2'(rq_tgt[i]), 16'(rq_pc[i])};
                    if (rq_both[i]) pr[4*i +: 4] = {1'b1, rq_junk[i]};
                end else begin
                    pr[4*i +: 4] = {1'b1, rq_kind[i] == 2, 2'(rq_tgt[i])};
                end
            end
        end
        pr_req = pr;
        aw_req = aw;
    endtask

    task automatic check_outputs(string tag);
        int          g;
        logic [11:0] es;
        logic [67:0] ep;
        g  = m_grant();
        es = '0;
        for (int i = 0; i < 4; i++) begin
            m_last_bp[i]  = m_bp(i, g);
            es[3*i +: 3]  = (m_paused[i] || m_last_bp[i]) ? 3'd6 : 3'd0;
        end
        ep = {m_pcp[3], m_pcp[2], m_pcp[1], m_pcp[0]};
        chk({tag, ".pcp"},   pc_passed, ep);
        chk({tag, ".stall"}, 68'(stall_num), 68'(es));
        chk({tag, ".halt"},  68'(all_halted), 68'(m_allh));
    endtask

    task automatic model_edge();
        int        g;
        bit        bp [4];
        bit [16:0] np [4];
        if (rst) begin
            model_reset();
            return;
        end
        g = m_grant();
        for (int i = 0; i < 4; i++) begin
            bp[i] = m_bp(i, g);
            np[i] = '0;
        end
        if (m_boot) begin
            np[0]  = {1'b1, BOOT_PC};
            m_boot = 1'b0;
        end else if (g >= 0) begin
            case (m_slot[g].kind)
                0:       np[m_slot[g].tgt] = {1'b1, 16'(m_slot[g].pc)};
                1:       m_paused[m_slot[g].tgt] = 1'b1;
                default: m_paused[m_slot[g].tgt] = 1'b0;
            endcase
            m_slot[g].full = 1'b0;
            m_rr = (g + 1) % 4;
        end
        for (int i = 0; i < 4; i++) begin
            if (rq_v[i] && !bp[i]) begin
                m_slot[i].full = 1'b1;
                m_slot[i].kind = rq_kind[i];
                m_slot[i].tgt  = rq_tgt[i];
                m_slot[i].pc   = (rq_kind[i] == 0) ? rq_pc[i] : 0;
            end
            m_pcp[i] = np[i];
        end
        m_allh = (core_awake != 4'd0) && ((core_awake & ~core_halt) == 4'd0);
    endtask

    // Drive, compare mid-cycle, advance one edge and update the model.
    task automatic tick(string tag);
        drive_inputs();
        @(negedge clk);
        check_outputs(tag);
        @(posedge clk);
        model_edge();
        #1;
    endtask

    initial begin
        rst        = 1'b1;
        core_halt  = '0;
        core_awake = '0;
        for (int i = 0; i < 4; i++) begin
            clr_req(i);
            rq_kind[i] = 0;
            rq_tgt[i]  = 0;
            rq_pc[i]   = 0;
            rq_junk[i] = '0;
        end
        drive_inputs();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_pcp",   pc_passed, '0);
        chk("reset_stall", 68'(stall_num), '0);
        chk("reset_halt",  68'(all_halted), '0);

        // Boot pulse on core 0 for exactly one cycle
        rst = 1'b0;
        tick("boot");
        expect_pcp(0, {1'b1, BOOT_PC}, "boot_pulse");
        chk("boot_others", 68'(pc_passed[67:17]), '0);
        tick("boot1");
        expect_pcp(0, 17'h0, "boot_once");

        // All four cores request together with rr_ptr at 0
        for (int i = 0; i < 4; i++) set_req(i, 0, i, 16'h0200 + i);
        tick("rr_N");
        set_req(0, 0, 0, 16'h0300);
        set_req(1, 0, 1, 16'h0301);
        clr_req(2);
        clr_req(3);
        drive_inputs();
        #1;
        expect_stall(0, 3'd0, "rr_c0_free");
        expect_stall(1, 3'd6, "rr_c1_bp");
        tick("rr_N1");
        expect_pcp(0, 17'h10200, "rr_g0");
        clr_req(0);
        drive_inputs();
        #1;
        expect_stall(1, 3'd0, "rr_c1_release");
        tick("rr_N2");
        clr_req(1);
        expect_pcp(1, 17'h10201, "rr_g1");
        tick("rr_N3");
        expect_pcp(2, 17'h10202, "rr_g2");
        tick("rr_N4");
        expect_pcp(3, 17'h10203, "rr_g3");
        tick("rr_N5");
        expect_pcp(0, 17'h10300, "rr_g0b");
        tick("rr_N6");
        expect_pcp(1, 17'h10301, "rr_g1b");
        tick("rr_idle");

        // Core 1 awakens core 2
        set_req(1, 0, 2, 16'h0100);
        tick("aw_N");
        clr_req(1);
        expect_pcp(2, 17'h0, "aw_N1");
        tick("aw_N1");
        expect_pcp(2, 17'h10100, "aw_N2");
        tick("aw_N2");
        expect_pcp(2, 17'h0, "aw_N3");

        // Core 0 pauses core 3, core 1 resumes it
        set_req(0, 1, 3, 0);
        tick("pause_N");
        clr_req(0);
        tick("pause_N1");
        expect_stall(3, 3'd6, "pause_N2");
        repeat (3) tick("paused");
        expect_stall(3, 3'd6, "pause_hold");
        set_req(1, 2, 3, 0);
        tick("resume_M");
        clr_req(1);
        expect_stall(3, 3'd6, "resume_M1");
        tick("resume_M1");
        expect_stall(3, 3'd0, "resume_M2");

        // Async reset while core 2 is paused and every slot is full
        core_awake = 4'b0001;
        core_halt  = 4'b0001;
        set_req(0, 1, 2, 0);
        tick("p2_N");
        clr_req(0);
        tick("p2_N1");
        for (int i = 0; i < 4; i++) set_req(i, 0, i, 16'h0400 + i);
        tick("full_A");
        drive_inputs();
        #1;
        expect_stall(2, 3'd6, "pre_rst_paused");
        chk("pre_rst_halt", 68'(all_halted), 68'(1));
        rst = 1'b1;
        #1;
        chk("async_pcp",   pc_passed, '0);
        chk("async_stall", 68'(stall_num), '0);
        chk("async_halt",  68'(all_halted), '0);
        model_reset();
        for (int i = 0; i < 4; i++) clr_req(i);
        tick("in_rst");
        rst = 1'b0;
        tick("reboot");
        expect_pcp(0, {1'b1, BOOT_PC}, "reboot_pulse");
        for (int k = 0; k < 4; k++) begin
            tick("no_replay");
            chk("no_replay_pcp", pc_passed, '0);
        end

        // Same-target awakens resolve in grant order
        set_req(1, 0, 3, 16'h0010);
        set_req(2, 0, 3, 16'h0020);
        tick("same_N");
        clr_req(1);
        clr_req(2);
        tick("same_N1");
        expect_pcp(3, 17'h10010, "same_first");
        tick("same_N2");
        expect_pcp(3, 17'h10020, "same_second");

        // all_halted boundary cases
        core_awake = 4'b0000;
        core_halt  = 4'b1111;
        tick("ah_none");
        chk("ah_none_awake", 68'(all_halted), 68'(0));
        core_awake = 4'b0110;
        core_halt  = 4'b0111;
        tick("ah_all");
        chk("ah_all_halted", 68'(all_halted), 68'(1));
        core_halt  = 4'b0100;
        tick("ah_one");
        chk("ah_one_running", 68'(all_halted), 68'(0));

        // Randomized traffic against the model
        for (int cyc = 0; cyc < 600; cyc++) begin
            if (cyc % 8 == 0) begin
                core_awake = 4'($urandom);
                core_halt  = ($urandom_range(0, 1) == 1) ? core_awake : 4'($urandom);
            end
            for (int i = 0; i < 4; i++) begin
                if (!(rq_v[i] && m_last_bp[i])) begin
                    rq_v[i]    = ($urandom_range(0, 2) == 0) && !core_halt[i];
                    rq_kind[i] = $urandom_range(0, 2);
                    rq_tgt[i]  = $urandom_range(0, 3);
                    rq_pc[i]   = $urandom_range(0, 65535);
                    rq_both[i] = ($urandom_range(0, 3) == 0);
                    rq_junk[i] = 3'($urandom);
                end
            end
            tick("rand");
        end
        for (int i = 0; i < 4; i++) clr_req(i);
        repeat (6) tick("drain");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
